// File: rtl/riscv_enc_pkg.sv
// Shared types, opcode constants and field-packing helpers for the RV32I
// instruction encoder. The optional immediate range checking is enabled by
// the RISCV_ENC_CHECK_EN macro in riscv_insn_encode.
package riscv_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_IMM    = 7'h13;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_REG    = 7'h33;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_JAL    = 7'h6F;

    localparam int unsigned INSN_W  = 32;
    localparam int unsigned ENTRY_W = INSN_W + 1;  // {err, insn}

    // Packs the fields into an RV32I word; undefined formats give all zeros.
    function automatic logic [INSN_W-1:0] encode_fields(
        input logic [2:0]  fmt,
        input logic [6:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        logic [INSN_W-1:0] w;
        w = '0;
        case (fmt_e'(fmt))
            FMT_R:   w = {f7, rs2, rs1, f3, rd, op};
            FMT_I:   w = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   w = {imm[31:12], rd, op};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: w = '0;
        endcase
        return w;
    endfunction

    // True when the immediate cannot be represented exactly by the format,
    // or the format code is undefined. Range tests reduce to "all bits above
    // the field's sign bit equal the sign bit".
    function automatic logic imm_illegal(
        input logic [2:0]  fmt,
        input logic [31:0] imm
    );
        logic bad;
        bad = 1'b0;
        case (fmt_e'(fmt))
            FMT_R:          bad = 1'b0;
            FMT_I, FMT_S:   bad = (imm[31:11] != {21{imm[11]}});
            FMT_B:          bad = (imm[31:12] != {20{imm[12]}}) || imm[0];
            FMT_U:          bad = (imm[11:0] != 12'h000);
            FMT_J:          bad = (imm[31:20] != {12{imm[20]}}) || imm[0];
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/riscv_enc_fifo.sv
// Output FIFO for the encoder: DEPTH entries (power of two), registered
// write-ready, head data forced to zero while empty.
module riscv_enc_fifo
    import riscv_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    next_count;
    logic             rdy;
    logic             do_push;
    logic             do_pop;

    assign do_push  = wr_valid && rdy;
    assign do_pop   = (count != '0) && rd_ready;
    assign wr_ready = rdy;
    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rptr] : '0;

    // Occupancy after this cycle's push/pop
    always_comb begin
        next_count = count;
        if (do_push && !do_pop) begin
            next_count = count + CW'(1);
        end else if (do_pop && !do_push) begin
            next_count = count - CW'(1);
        end
    end

    // Pointers, count and the registered ready flag; ready is held low
    // during reset and rises on the first edge with rst_n high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rdy   <= 1'b0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            count <= next_count;
            rdy   <= (next_count < CW'(DEPTH));
        end
    end

    // Storage write; contents need no reset since the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wr_data;
        end
    end

endmodule

// File: rtl/riscv_insn_encode.sv
// RV32I field-set to instruction-word encoder with a DEPTH-entry output FIFO.
// Optional macro RISCV_ENC_CHECK_EN flags unrepresentable immediates and
// undefined formats on out_err; without it out_err stays 0 and excess
// immediate bits are dropped.
module riscv_insn_encode
    import riscv_enc_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_insn,
    output logic        out_err
);

    logic [INSN_W-1:0]  enc_insn;
    logic               enc_err;
    logic [ENTRY_W-1:0] head;

    // Combinational encode of the offered field set
    always_comb begin
        enc_insn = encode_fields(in_fmt, in_opcode, in_rd, in_rs1, in_rs2,
                                 in_funct3, in_funct7, in_imm);
        enc_err  = 1'b0;
`ifdef RISCV_ENC_CHECK_EN
        enc_err  = imm_illegal(in_fmt, in_imm);
`else
        enc_err  = 1'b0;
`endif
    end

    riscv_enc_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  ({enc_err, enc_insn}),
        .rd_valid (out_valid),
        .rd_ready (out_ready),
        .rd_data  (head)
    );

    assign out_err  = head[ENTRY_W-1];
    assign out_insn = head[INSN_W-1:0];

endmodule
